// File: rtl/rv32_pkg.sv
// Shared RV32 decode types: immediate format enum, opcodes,
// and the decoded entry stored in the instruction buffer.
package rv32_pkg;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        S    = 3'd2,
        SB   = 3'd3,
        UJ   = 3'd4,
        U    = 3'd5
    } inst_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [31:0] imm;
        inst_t       typ;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational opcode classification and immediate extraction.
// Register-register ops are legal but carry no immediate.
module imm_extract
    import rv32_pkg::*;
(
    input  logic [31:0] inst,
    output entry_t      dec
);

    logic [6:0] opc;

    assign opc = inst[6:0];

    always_comb begin
        dec = '0;
        unique case (opc)
            OP_IMM, OP_LOAD, OP_JALR: begin
                dec.typ = I;
                dec.imm = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                dec.typ = S;
                dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                dec.typ = SB;
                dec.imm = {{21{inst[31]}}, inst[7], inst[30:25], inst[11:8]};
            end
            OP_JAL: begin
                dec.typ = UJ;
                dec.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[31:21]};
            end
            OP_LUI, OP_AUIPC: begin
                dec.typ = U;
                dec.imm = {inst[31:12], 12'd0};
            end
            OP_REG: begin
                dec.typ = NONE;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Two-entry decoded-immediate buffer with valid/ready handshakes,
// flush, and saturating emit / illegal-emit counters.
module imm_decode_ctrl
    import rv32_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid_i,
    input  logic [31:0]      inst_i,
    output logic             inst_ready_o,
    input  logic             flush_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [31:0]      imm_o,
    output logic [2:0]       type_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] decoded_cnt_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    entry_t           buf_q [2];
    entry_t           dec;
    logic             ready_q;
    logic             accept;
    logic             emit;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] icnt_q;

    imm_extract u_ext (
        .inst (inst_i),
        .dec  (dec)
    );

    assign accept = inst_valid_i & ready_q;
    assign emit   = (state_q != EMPTY) & out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !emit)      state_d = FULL;
                    else if (emit && !accept) state_d = EMPTY;
                end
                FULL: if (emit) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Ready is registered from the next state, so it tracks state != FULL
    // and stays low during reset until the first clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= (state_d != FULL);
    end

    // Entry 0 is always the head; entry 1 shifts down on a FULL emit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (flush_i) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) buf_q[0] <= dec;
                ONE: begin
                    if (accept && emit) buf_q[0] <= dec;
                    else if (accept)    buf_q[1] <= dec;
                    else if (emit)      buf_q[0] <= '0;
                end
                FULL: begin
                    if (emit) begin
                        buf_q[0] <= buf_q[1];
                        buf_q[1] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_q <= '0;
            icnt_q <= '0;
        end else if (emit && !flush_i) begin
            if (dcnt_q != '1) dcnt_q <= dcnt_q + 1'b1;
            if (buf_q[0].illegal && icnt_q != '1) icnt_q <= icnt_q + 1'b1;
        end
    end

    always_comb begin
        out_valid_o = (state_q != EMPTY);
        imm_o       = '0;
        type_o      = '0;
        illegal_o   = 1'b0;
        if (out_valid_o) begin
            imm_o     = buf_q[0].imm;
            type_o    = buf_q[0].typ;
            illegal_o = buf_q[0].illegal;
        end
    end

    assign inst_ready_o  = ready_q;
    assign decoded_cnt_o = dcnt_q;
    assign illegal_cnt_o = icnt_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Randomised and directed bench for imm_decode_ctrl against a
// queue-based reference model of the decoded-instruction buffer.
module tb_imm_decode_ctrl;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inst_valid_i = 1'b0;
    logic [31:0]   inst_i = '0;
    logic          inst_ready_o;
    logic          flush_i = 1'b0;
    logic          out_ready_i = 1'b0;
    logic          out_valid_o;
    logic [31:0]   imm_o;
    logic [2:0]    type_o;
    logic          illegal_o;
    logic [CW-1:0] decoded_cnt_o;
    logic [CW-1:0] illegal_cnt_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] imm;
        int          typ;
        logic        ill;
    } exp_t;

    exp_t q[$];
    logic ready_m = 1'b0;
    int   dcnt_m = 0;
    int   icnt_m = 0;

    logic [6:0] opc_tab [10] = '{7'b0010011, 7'b0000011, 7'b1100111,
                                 7'b0100011, 7'b1100011, 7'b1101111,
                                 7'b0110111, 7'b0010111, 7'b0110011,
                                 7'b1111111};

    imm_decode_ctrl #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_valid_i  (inst_valid_i),
        .inst_i        (inst_i),
        .inst_ready_o  (inst_ready_o),
        .flush_i       (flush_i),
        .out_ready_i   (out_ready_i),
        .out_valid_o   (out_valid_o),
        .imm_o         (imm_o),
        .type_o        (type_o),
        .illegal_o     (illegal_o),
        .decoded_cnt_o (decoded_cnt_o),
        .illegal_cnt_o (illegal_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode from the field-placement rules, via shifts and masks.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        logic signed [31:0] s;
        logic [31:0] sx;
        s = w;
        sx = s >>> 31;
        e.imm = 0;
        e.typ = 0;
        e.ill = 1'b0;
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.typ = 1;
                e.imm = s >>> 20;
            end
            7'b0100011: begin
                e.typ = 2;
                e.imm = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
            end
            7'b1100011: begin
                e.typ = 3;
                e.imm = (sx << 11) | (32'(w[7]) << 10)
                      | (32'(w[30:25]) << 4) | 32'(w[11:8]);
            end
            7'b1101111: begin
                e.typ = 4;
                e.imm = (sx << 20) | (32'(w[19:12]) << 12)
                      | (32'(w[20]) << 11) | 32'(w[31:21]);
            end
            7'b0110111, 7'b0010111: begin
                e.typ = 5;
                e.imm = w & 32'hFFFF_F000;
            end
            7'b0110011: ;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        logic v;
        v = (q.size() != 0);
        check({tag, ".valid"}, 32'(out_valid_o), 32'(v));
        check({tag, ".imm"}, imm_o, v ? q[0].imm : 32'd0);
        check({tag, ".type"}, 32'(type_o), v ? 32'(q[0].typ) : 32'd0);
        check({tag, ".ill"}, 32'(illegal_o), v ? 32'(q[0].ill) : 32'd0);
        check({tag, ".ready"}, 32'(inst_ready_o), 32'(ready_m));
        check({tag, ".dcnt"}, 32'(decoded_cnt_o), 32'(dcnt_m));
        check({tag, ".icnt"}, 32'(illegal_cnt_o), 32'(icnt_m));
    endtask

    // Entered at a negedge; checks, drives, advances model, returns at negedge.
    task automatic cycle(input string tag, input logic v,
                         input logic [31:0] w, input logic rdy,
                         input logic fl);
        logic acc;
        logic emt;
        exp_t e;
        check_outputs(tag);
        inst_valid_i = v;
        inst_i       = w;
        out_ready_i  = rdy;
        flush_i      = fl;
        acc = v && ready_m;
        emt = rdy && (q.size() != 0);
        e = ref_decode(w);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (emt) begin
                if (dcnt_m < CMAX) dcnt_m++;
                if (q[0].ill && icnt_m < CMAX) icnt_m++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
        end
        ready_m = (q.size() != 2);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        w[6:0] = opc_tab[$urandom_range(0, 9)];
        if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom);
        return w;
    endfunction

    initial begin
        #3;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        cycle("rel", 1'b1, 32'hFFF0_0093, 1'b1, 1'b0);
        cycle("addi", 1'b1, 32'hFFF0_0093, 1'b1, 1'b0);
        check("addi.imm_direct", imm_o, 32'hFFFF_FFFF);
        cycle("sw", 1'b1, 32'h0011_2623, 1'b1, 1'b0);
        check("sw.imm_direct", imm_o, 32'h0000_000C);
        cycle("lui", 1'b1, 32'h1234_5037, 1'b1, 1'b0);
        check("lui.imm_direct", imm_o, 32'h1234_5000);
        cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0);

        cycle("bp0", 1'b1, 32'h0050_0093, 1'b0, 1'b0);
        cycle("bp1", 1'b1, 32'h00A0_0113, 1'b0, 1'b0);
        cycle("bp2", 1'b1, 32'h00F0_0193, 1'b0, 1'b0);
        check("bp.full_ready", 32'(inst_ready_o), 32'd0);
        cycle("bp3", 1'b1, 32'h00F0_0193, 1'b1, 1'b0);
        cycle("bp4", 1'b1, 32'h00F0_0193, 1'b1, 1'b0);
        cycle("bp5", 1'b0, 32'h0, 1'b1, 1'b0);

        cycle("ill", 1'b1, 32'h0000_007F, 1'b1, 1'b0);
        cycle("ill.emit", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("ill.done", 1'b0, 32'h0, 1'b1, 1'b0);

        cycle("fl0", 1'b1, 32'h0011_2623, 1'b0, 1'b0);
        cycle("fl1", 1'b1, 32'h1234_5037, 1'b0, 1'b0);
        cycle("fl2", 1'b1, 32'hFFF0_0093, 1'b1, 1'b1);
        cycle("fl3", 1'b0, 32'h0, 1'b0, 1'b0);

        cycle("rs0", 1'b1, 32'h0011_2623, 1'b0, 1'b0);
        cycle("rs1", 1'b1, 32'h1234_5037, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        q.delete();
        ready_m = 1'b0;
        dcnt_m = 0;
        icnt_m = 0;
        check_outputs("rst.async");
        @(negedge clk);
        rst = 1'b0;
        cycle("rs2", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("rs3", 1'b0, 32'h0, 1'b1, 1'b0);

        for (int n = 0; n < 600; n++) begin
            cycle("rnd", $urandom_range(0, 3) != 0, rand_inst(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        check_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_decode_ctrl.md
IMM_DECODE_CTRL -- requirements
Module: imm_decode_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the decoded-instruction and illegal-instruction counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 inst_valid_i  input  1  upstream instruction valid.
REQ-005 inst_i  input  32  instruction word.
REQ-006 inst_ready_o  output  1  the block can accept an instruction this cycle.
REQ-007 flush_i  input  1  discard all buffered instructions.
REQ-008 out_ready_i  input  1  downstream accepts the head entry.
REQ-009 out_valid_o  output  1  head entry valid.
REQ-010 imm_o  output  32  head entry immediate.
REQ-011 type_o  output  3  head entry immediate type (0 none, 1 I, 2 S, 3 SB, 4 UJ, 5 U).
REQ-012 illegal_o  output  1  head entry opcode unrecognised.
REQ-013 decoded_cnt_o  output  CNT_W  count of entries emitted, saturating.
REQ-014 illegal_cnt_o  output  CNT_W  count of emitted entries with illegal set, saturating.

Function
REQ-015 Opcode inst_i[6:0] SHALL map as follows: 0010011, 0000011 and 1100111 to I; 0100011 to S; 1100011 to SB; 1101111 to UJ; 0110111 and 0010111 to U; 0110011 to type 0 with imm 0; all other opcodes to type 0, imm 0, illegal 1.
REQ-016 Immediates SHALL be formed as follows:
  - I: {20{i[31]}, i[31:20]}
  - S: {20{i[31]}, i[31:25], i[11:7]}
  - SB: {21{i[31]}, i[7], i[30:25], i[11:8]}
  - UJ: {12{i[31]}, i[19:12], i[20], i[31:21]}
  - U: {i[31:12], 12'd0}
REQ-017 An accept SHALL occur when inst_valid_i and inst_ready_o are both high; an emit SHALL occur when out_valid_o and out_ready_i are both high.
REQ-018 The entry buffer SHALL be 2 deep, with FSM states EMPTY, ONE and FULL.
REQ-019 In EMPTY, an accept SHALL move the state to ONE.
REQ-020 In ONE:
  - accept with no emit SHALL move to FULL.
  - emit with no accept SHALL move to EMPTY.
  - accept and emit together SHALL stay in ONE.
REQ-021 In FULL, an emit SHALL move the state to ONE.
REQ-022 inst_ready_o SHALL be registered and equal (state != FULL); no accept SHALL occur in FULL.
REQ-023 Latency SHALL be 1 cycle: an instruction accepted in cycle N appears on the outputs in cycle N+1 when the buffer was EMPTY, or when it was ONE with an emit in cycle N.
REQ-024 The outputs SHALL present the oldest entry (FIFO order); imm_o, type_o and illegal_o SHALL stay stable while out_valid_o is high and out_ready_i is low.
REQ-025 Decode SHALL happen at accept time; the buffer stores {imm, type, illegal}, not the raw instruction.
REQ-026 A flush SHALL force EMPTY on the next edge, override any same-cycle accept or emit, leave the counters unchanged, and restore inst_ready_o to 1 one cycle later.
REQ-027 decoded_cnt_o SHALL increment on each emit; illegal_cnt_o SHALL increment on each emit with illegal_o high.
REQ-028 Both counters SHALL hold at all-ones rather than wrap.
REQ-029 When out_valid_o is 0, imm_o, type_o and illegal_o SHALL be 0.

Reset
REQ-030 On rst high, the block SHALL asynchronously set state to EMPTY, out_valid_o 0, inst_ready_o 0, imm_o, type_o, illegal_o and both counters 0, and all buffer entries 0.
REQ-031 inst_ready_o SHALL rise on the first clk edge after rst deasserts.
REQ-032 A reset asserted mid-operation SHALL discard buffered entries with no emit.

Structure
REQ-033 The inst_t enum (NONE=0, I=1, S=2, SB=3, UJ=4, U=5) and the opcode constants SHALL live in shared package rv32_pkg.
REQ-034 The combinational opcode-to-type decode and immediate extraction SHALL be one sub-module, imm_extract; buffer, FSM and counters SHALL live in imm_decode_ctrl.

Verification
REQ-035 Accept 0xFFF00093 with out_ready_i=1 -> next cycle: out_valid_o 1, type_o 1, imm_o 0xFFFFFFFF, illegal_o 0.
REQ-036 Accept 0x00112623 -> type_o 2, imm_o 0x0000000C. Accept 0x12345037 -> type_o 5, imm_o 0x12345000.
REQ-037 Hold out_ready_i=0 and offer three instructions -> first two accepted, inst_ready_o 0 after the second accept. Then raise out_ready_i -> emits in FIFO order, third accepted, decoded_cnt_o ends at 3.
REQ-038 Accept 0x0000007F -> illegal_o 1, type_o 0, imm_o 0, illegal_cnt_o 1 after the emit.
REQ-039 In FULL, assert flush_i and inst_valid_i together -> next cycle out_valid_o 0, state EMPTY, counters unchanged, no new entry.
REQ-040 Assert rst asynchronously mid-stream with two entries buffered -> outputs and counters 0 immediately; no emit after release.
